// File: rtl/ptw_axi_pkg.sv
// AXI4 read-channel constants and walker FSM encoding shared by the PTE fetch master.
package ptw_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'd3;

  // Normal non-cacheable bufferable, privileged data access.
  localparam logic [3:0] ARCACHE_VAL = 4'b0011;
  localparam logic [2:0] ARPROT_VAL  = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    R     = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ptw_axi_read_master.sv
// Single-beat AXI4 read per PTE request; PTE or fault pulse one cycle after the R beat (>=3 cycles total).
// AR held until ARREADY, RREADY always high while waiting; requests arriving while busy are dropped.
module ptw_axi_read_master
  import ptw_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ADDR_IN_VALID,
  input  logic [ADDR_WIDTH-1:0]   ADDR_IN,
  input  logic                    ABORT,
  output logic                    DATA_OUT_VALID,
  output logic [DATA_WIDTH-1:0]   DATA_OUT,
  output logic                    ACCESS_FAULT,
  output logic                    BUSY,
  output logic [AXI_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]              M_AXI_ARLEN,
  output logic [2:0]              M_AXI_ARSIZE,
  output logic [1:0]              M_AXI_ARBURST,
  output logic [3:0]              M_AXI_ARCACHE,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [AXI_ID_WIDTH-1:0] M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RLAST,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]         CNT_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(7);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   araddr_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    dov_nxt, fault_nxt;
  logic                    abort_pend, abort_pend_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    r_err;

  assign M_AXI_ARID    = AXI_ID_WIDTH'(AXI_ID);
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = SIZE_8B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARCACHE = ARCACHE_VAL;
  assign M_AXI_ARPROT  = ARPROT_VAL;
  assign M_AXI_ARVALID = (state == AR);
  assign M_AXI_RREADY  = (state == R) || (state == DRAIN);
  assign BUSY          = (state != IDLE);

  // A multi-beat response is also a protocol error: the fault is reported and the tail drained.
  assign r_err = (M_AXI_RRESP != RESP_OKAY) ||
                 (M_AXI_RID != AXI_ID_WIDTH'(AXI_ID)) || !M_AXI_RLAST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      M_AXI_ARADDR   <= '0;
      DATA_OUT       <= '0;
      DATA_OUT_VALID <= 1'b0;
      ACCESS_FAULT   <= 1'b0;
      abort_pend     <= 1'b0;
      cnt            <= '0;
    end else begin
      state          <= state_nxt;
      M_AXI_ARADDR   <= araddr_nxt;
      DATA_OUT       <= data_nxt;
      DATA_OUT_VALID <= dov_nxt;
      ACCESS_FAULT   <= fault_nxt;
      abort_pend     <= abort_pend_nxt;
      cnt            <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    araddr_nxt     = M_AXI_ARADDR;
    data_nxt       = DATA_OUT;
    dov_nxt        = 1'b0;
    fault_nxt      = 1'b0;
    abort_pend_nxt = abort_pend;
    cnt_nxt        = cnt;
    case (state)
      IDLE: begin
        abort_pend_nxt = 1'b0;
        if (ADDR_IN_VALID && !ABORT) begin
          araddr_nxt = ADDR_IN & ALIGN_MASK;
          state_nxt  = AR;
        end
      end
      AR: begin
        if (ABORT) abort_pend_nxt = 1'b1;
        if (M_AXI_ARREADY) begin
          // The read is already issued, so an aborted walk must still swallow its beat.
          cnt_nxt        = '0;
          abort_pend_nxt = 1'b0;
          state_nxt      = (abort_pend || ABORT) ? DRAIN : R;
        end
      end
      R: begin
        if (M_AXI_RVALID) begin
          if (ABORT) begin
            state_nxt = IDLE;
          end else if (r_err) begin
            fault_nxt = 1'b1;
            data_nxt  = '0;
            state_nxt = M_AXI_RLAST ? IDLE : DRAIN;
          end else begin
            dov_nxt   = 1'b1;
            data_nxt  = M_AXI_RDATA;
            state_nxt = IDLE;
          end
        end else if (ABORT) begin
          state_nxt = DRAIN;
        end else if (cnt == CNT_LAST) begin
          fault_nxt = 1'b1;
          data_nxt  = '0;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (M_AXI_RVALID && M_AXI_RLAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
